// File: rtl/intr_src_if.sv
// CPU I/O-port bus between the SOC address decoder and the intr_src register file.
interface intr_src_if;
  // Strobe semantics: a write commits on the rising clock edge of any cycle with
  // io_sel & io_wr; a read is combinational and io_dout is nonzero only while
  // io_sel & io_rd. There is no back-pressure, so every strobe completes in its cycle.
  logic       io_sel;
  logic [1:0] io_addr;
  logic       io_wr;
  logic       io_rd;
  logic [7:0] io_din;
  logic [7:0] io_dout;

  modport master (
    output io_sel, io_addr, io_wr, io_rd, io_din,
    input  io_dout
  );

  modport slave (
    input  io_sel, io_addr, io_wr, io_rd, io_din,
    output io_dout
  );
endinterface

// File: rtl/intr_src.sv
// Interrupt source front-end: synchronizes and glitch-filters four raw pins, applies
// per-channel level/edge mode and exposes INTEN/MODE/RAW/EDGE on the CPU I/O bus.
module intr_src #(
  parameter int FILT_CNT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  irq_pin,
  intr_src_if.slave   bus,
  output logic [3:0]  ext_intr,
  output logic [3:0]  intr_ena
);
  localparam logic [7:0] CNT_LAST = 8'(FILT_CNT - 1);

  logic [3:0] s1_q, s1_d;
  logic [3:0] s2_q, s2_d;
  logic [7:0] cnt_q [4];
  logic [7:0] cnt_d [4];
  logic [3:0] filt_q, filt_d;
  logic [3:0] ext_intr_q, ext_intr_d;
  logic [3:0] inten_q, inten_d;
  logic [3:0] mode_q, mode_d;
  logic [3:0] edge_flag_q, edge_flag_d;

  logic       wr_en;
  logic [3:0] rise;
  logic [3:0] w1c;
  logic [3:0] rd_data;
  logic       unused_din_hi;

  assign unused_din_hi = &{1'b0, bus.io_din[7:4]};

  always_comb begin
    s1_d   = irq_pin;
    s2_d   = s1_q;
    filt_d = filt_q;
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = cnt_q[i];
      // Any return of s2 to the filtered level restarts the qualification count.
      if (s2_q[i] == filt_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = s2_q[i];
        cnt_d[i]  = 8'd0;
      end else begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end

    wr_en   = bus.io_sel & bus.io_wr;
    inten_d = (wr_en && bus.io_addr == 2'd0) ? bus.io_din[3:0] : inten_q;
    mode_d  = (wr_en && bus.io_addr == 2'd1) ? bus.io_din[3:0] : mode_q;
    w1c     = (wr_en && bus.io_addr == 2'd3) ? bus.io_din[3:0] : 4'h0;

    rise = filt_d & ~filt_q;
    // A new rising edge wins over a same-cycle clear.
    edge_flag_d = (edge_flag_q & ~w1c) | rise;

    // The incoming mode selects the output on the write edge itself, so a mode
    // change never fabricates a pulse from an already-high filtered level.
    for (int i = 0; i < 4; i++) begin
      ext_intr_d[i] = mode_d[i] ? rise[i] : filt_d[i];
    end
  end

  always_comb begin
    rd_data = 4'h0;
    case (bus.io_addr)
      2'd0: rd_data = inten_q;
      2'd1: rd_data = mode_q;
      2'd2: rd_data = filt_q;
      2'd3: rd_data = edge_flag_q;
      default: rd_data = 4'h0;
    endcase
  end

  assign bus.io_dout = (bus.io_sel & bus.io_rd) ? {4'h0, rd_data} : 8'h00;
  assign ext_intr    = ext_intr_q;
  assign intr_ena    = inten_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_q        <= 4'h0;
      s2_q        <= 4'h0;
      filt_q      <= 4'h0;
      ext_intr_q  <= 4'h0;
      inten_q     <= 4'h0;
      mode_q      <= 4'h0;
      edge_flag_q <= 4'h0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      filt_q      <= filt_d;
      ext_intr_q  <= ext_intr_d;
      inten_q     <= inten_d;
      mode_q      <= mode_d;
      edge_flag_q <= edge_flag_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule

// File: tb/tb_intr_src.sv
// Directed bench for intr_src with FILT_CNT=4; all expected values are hand-derived.
module tb_intr_src;
  logic       clock;
  logic       reset;
  logic [3:0] irq_pin;
  logic [3:0] ext_intr;
  logic [3:0] intr_ena;

  int checks = 0;
  int errors = 0;

  intr_src_if bus_if();

  intr_src #(.FILT_CNT(4)) dut (
    .clock    (clock),
    .reset    (reset),
    .irq_pin  (irq_pin),
    .bus      (bus_if),
    .ext_intr (ext_intr),
    .intr_ena (intr_ena)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.io_sel  = 1'b0;
    bus_if.io_wr   = 1'b0;
    bus_if.io_rd   = 1'b0;
    bus_if.io_addr = 2'd0;
    bus_if.io_din  = 8'h00;
  endtask

  task automatic reg_wr(input logic [1:0] addr, input logic [7:0] data);
    bus_if.io_sel  = 1'b1;
    bus_if.io_wr   = 1'b1;
    bus_if.io_addr = addr;
    bus_if.io_din  = data;
    tick();
    bus_idle();
  endtask

  task automatic reg_chk(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    bus_if.io_sel  = 1'b1;
    bus_if.io_rd   = 1'b1;
    bus_if.io_addr = addr;
    #1;
    check(tag, bus_if.io_dout, exp);
    bus_idle();
  endtask

  initial begin
    int hi_cnt;
    logic [3:0] seen;

    reset   = 1'b0;
    irq_pin = 4'h0;
    bus_idle();
    #12;

    // Reset state
    check("rst_ext_intr", {4'h0, ext_intr}, 8'h00);
    check("rst_intr_ena", {4'h0, intr_ena}, 8'h00);
    check("rst_dout_idle", bus_if.io_dout, 8'h00);
    reg_chk("rst_inten", 2'd0, 8'h00);
    reg_chk("rst_edge", 2'd3, 8'h00);
    tick();
    reset = 1'b1;
    tick();

    // Filter latency, level mode
    reg_wr(2'd0, 8'h0F);
    check("inten_out", {4'h0, intr_ena}, 8'h0F);
    reg_wr(2'd1, 8'h00);
    irq_pin[0] = 1'b1;
    seen = 4'h0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen |= ext_intr;
    end
    check("lat_before_e5", {4'h0, seen}, 8'h00);
    tick();
    check("lat_at_e5", {4'h0, ext_intr}, 8'h01);
    reg_chk("lat_raw", 2'd2, 8'h01);
    check("lat_intr_ena", {4'h0, intr_ena}, 8'h0F);
    reg_chk("lat_edge_set", 2'd3, 8'h01);
    reg_wr(2'd3, 8'h01);
    reg_chk("lat_edge_clr", 2'd3, 8'h00);

    // Mode switch while active
    reg_wr(2'd1, 8'h01);
    check("mode_to_edge", {4'h0, ext_intr}, 8'h00);
    seen = 4'h0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen |= ext_intr;
    end
    check("mode_no_pulse", {4'h0, seen}, 8'h00);
    reg_wr(2'd1, 8'h00);
    check("mode_to_level", {4'h0, ext_intr}, 8'h01);
    irq_pin[0] = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    check("fall_level", {4'h0, ext_intr}, 8'h00);
    reg_chk("fall_raw", 2'd2, 8'h00);

    // Glitch rejection: three cycles high never qualifies
    irq_pin[2] = 1'b1;
    tick(); tick(); tick();
    irq_pin[2] = 1'b0;
    seen = 4'h0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen |= ext_intr;
    end
    check("glitch_ext", {4'h0, seen}, 8'h00);
    reg_chk("glitch_raw", 2'd2, 8'h00);
    reg_chk("glitch_edge", 2'd3, 8'h00);
    irq_pin[2] = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    reg_chk("stable_raw", 2'd2, 8'h04);
    reg_wr(2'd3, 8'h04);
    irq_pin[2] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    reg_chk("stable_fall_raw", 2'd2, 8'h00);

    // Edge mode pulse
    reg_wr(2'd1, 8'h02);
    irq_pin[1] = 1'b1;
    hi_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (ext_intr[1]) hi_cnt++;
    end
    check("edge_pulse_len", 8'(hi_cnt), 8'h01);
    check("edge_after", {4'h0, ext_intr}, 8'h00);
    reg_chk("edge_flag", 2'd3, 8'h02);
    reg_wr(2'd3, 8'h02);
    reg_chk("edge_w1c", 2'd3, 8'h00);
    irq_pin[1] = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    // Set beats clear: filt[3] rises on the sixth edge after the pin goes high
    irq_pin[3] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    reg_chk("sbc_raw_pre", 2'd2, 8'h00);
    reg_wr(2'd3, 8'h08);
    reg_chk("sbc_edge", 2'd3, 8'h08);
    reg_chk("sbc_raw", 2'd2, 8'h08);

    // Simultaneous read/write returns pre-write value; upper bits ignored
    bus_if.io_sel  = 1'b1;
    bus_if.io_wr   = 1'b1;
    bus_if.io_rd   = 1'b1;
    bus_if.io_addr = 2'd0;
    bus_if.io_din  = 8'hF5;
    #1;
    check("rdwr_prewrite", bus_if.io_dout, 8'h0F);
    tick();
    bus_idle();
    check("rdwr_intr_ena", {4'h0, intr_ena}, 8'h05);
    reg_chk("rdwr_inten", 2'd0, 8'h05);
    reg_wr(2'd2, 8'hFF);
    reg_chk("raw_ro", 2'd2, 8'h08);

    // Mid-operation reset with pin0 mid-count and pin3 high
    reg_wr(2'd1, 8'h00);
    check("pre_rst_ext", {4'h0, ext_intr}, 8'h08);
    irq_pin[0] = 1'b1;
    tick(); tick(); tick();
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_ext", {4'h0, ext_intr}, 8'h00);
    check("mid_rst_ena", {4'h0, intr_ena}, 8'h00);
    reg_chk("mid_rst_inten", 2'd0, 8'h00);
    reg_chk("mid_rst_mode", 2'd1, 8'h00);
    reg_chk("mid_rst_raw", 2'd2, 8'h00);
    reg_chk("mid_rst_edge", 2'd3, 8'h00);
    tick();
    reset = 1'b1;
    seen = 4'h0;
    for (int k = 0; k < 5; k++) begin
      tick();
      seen |= ext_intr;
    end
    check("post_rst_before", {4'h0, seen}, 8'h00);
    tick();
    check("post_rst_fresh", {4'h0, ext_intr}, 8'h09);
    reg_chk("post_rst_edge", 2'd3, 8'h09);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
